dbus_ctrl: RTL and testbench



---
 rtl/dbus_ctrl.sv | 105 ++++++++++
 tb/tb_dbus_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dbus_ctrl.sv
// Converts the memory stage's per-instruction access into one handshaked data-bus
// transaction (addr_ok request phase, data_ok response phase) and stalls until it completes.
module dbus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_size,
  input  logic [DATA_W/8-1:0] req_strobe,
  input  logic [DATA_W-1:0]   req_data,
  input  logic                m_advance,
  input  logic                flush,
  output logic                stall,
  output logic [DATA_W-1:0]   rd,
  output logic                dreq_valid,
  output logic                dreq_write,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic [2:0]          dreq_size,
  output logic [DATA_W/8-1:0] dreq_strobe,
  output logic [DATA_W-1:0]   dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [DATA_W-1:0]   dresp_data
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  typedef struct packed {
    logic                write;
    logic [ADDR_W-1:0]   addr;
    logic [2:0]          size;
    logic [DATA_W/8-1:0] strobe;
    logic [DATA_W-1:0]   data;
  } req_t;

  state_t state, state_nxt;
  logic   discard, discard_nxt;
  req_t   req_q;
  logic   req_load, rd_load, kill, resp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    req_load    = 1'b0;
    rd_load     = 1'b0;
    kill        = discard | flush;
    // Response lands either with the accept (zero-wait) or later in DATA.
    resp        = ((state == ADDR) & dresp_addr_ok & dresp_data_ok) |
                  ((state == DATA) & dresp_data_ok);
    case (state)
      IDLE: if (req_valid && !flush) begin
        req_load  = 1'b1;
        state_nxt = ADDR;
      end
      ADDR, DATA: begin
        // A killed access still drains the bus; only its result is dropped.
        discard_nxt = kill;
        if (resp) begin
          discard_nxt = 1'b0;
          state_nxt   = kill ? IDLE : DONE;
          rd_load     = ~kill & ~req_q.write;
        end else if (state == ADDR && dresp_addr_ok) begin
          state_nxt = DATA;
        end
      end
      DONE: if (m_advance || flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q <= '0;
      rd    <= '0;
    end else begin
      if (req_load) req_q <= '{req_write, req_addr, req_size, req_strobe, req_data};
      if (rd_load)  rd    <= dresp_data;
    end
  end

  assign dreq_valid  = (state == ADDR);
  assign dreq_write  = req_q.write;
  assign dreq_addr   = req_q.addr;
  assign dreq_size   = req_q.size;
  assign dreq_strobe = req_q.strobe;
  assign dreq_data   = req_q.data;

  // While discarding, state is never DONE, so stall simply follows req_valid.
  assign stall = resetn & req_valid & (discard | (state != DONE));

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: bus handshakes driven step by step, load results
// predicted into a scoreboard queue and popped when the access reaches DONE.
module tb_dbus_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_size;
  logic [DW/8-1:0] req_strobe;
  logic [DW-1:0] req_data;
  logic          m_advance, flush;
  logic          stall;
  logic [DW-1:0] rd;
  logic          dreq_valid, dreq_write;
  logic [AW-1:0] dreq_addr;
  logic [2:0]    dreq_size;
  logic [DW/8-1:0] dreq_strobe;
  logic [DW-1:0] dreq_data;
  logic          dresp_addr_ok, dresp_data_ok;
  logic [DW-1:0] dresp_data;

  int nchk = 0;
  int nerr = 0;
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] model_rd;

  always #5 clk = ~clk;

  dbus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .m_advance(m_advance), .flush(flush), .stall(stall), .rd(rd),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and drop the one-cycle pulses.
  task automatic nc();
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    m_advance     = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic pop_rd(input string tag);
    nchk++;
    assert (exp_rd.size() > 0) else begin
      nerr++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end
    if (exp_rd.size() > 0) chk(tag, rd, exp_rd.pop_front());
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [3:0] sb, input logic [31:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz;
    req_strobe = sb; req_data = d;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_strobe = '0; req_data = '0; m_advance = 1'b0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0; model_rd = '0;

    // Reset state
    nc(); #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dvalid", 32'(dreq_valid), 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_daddr", dreq_addr, 32'd0);
    req_valid = 1'b0;
    nc(); resetn = 1'b1;

    // 1: zero-wait load
    nc(); issue(1'b0, 32'h8000_0010, 3'd2, 4'hf, 32'h0);
    model_rd = 32'hDEAD_BEEF; exp_rd.push_back(model_rd); #1;
    chk("t1_stall_idle", 32'(stall), 32'd1);
    chk("t1_dvalid_idle", 32'(dreq_valid), 32'd0);
    nc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hDEAD_BEEF; #1;
    chk("t1_dvalid", 32'(dreq_valid), 32'd1);
    chk("t1_stall_addr", 32'(stall), 32'd1);
    chk("t1_daddr", dreq_addr, 32'h8000_0010);
    chk("t1_dwrite", 32'(dreq_write), 32'd0);
    nc(); m_advance = 1'b1; #1;
    chk("t1_stall_done", 32'(stall), 32'd0);
    chk("t1_dvalid_done", 32'(dreq_valid), 32'd0);
    pop_rd("t1_rd");
    nc(); req_valid = 1'b0; #1;
    chk("t1_idle_dvalid", 32'(dreq_valid), 32'd0);

    // 2: delayed load, inputs scribbled after latch to prove the hold
    nc(); issue(1'b0, 32'h0000_0100, 3'd1, 4'h3, 32'h0);
    model_rd = 32'h1234_5678; exp_rd.push_back(model_rd); #1;
    chk("t2_stall_idle", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      nc(); req_addr = 32'hFFFF_FFF0 + 32'(i); req_size = 3'd7;
      dresp_addr_ok = (i == 3); #1;
      chk("t2_dvalid", 32'(dreq_valid), 32'd1);
      chk("t2_daddr", dreq_addr, 32'h0000_0100);
      chk("t2_dsize", 32'(dreq_size), 32'd1);
      chk("t2_stall_addr", 32'(stall), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      nc(); dresp_data_ok = (i == 3); dresp_data = 32'h1234_5678; #1;
      chk("t2_dvalid_data", 32'(dreq_valid), 32'd0);
      chk("t2_stall_data", 32'(stall), 32'd1);
    end
    nc(); m_advance = 1'b1; #1;
    chk("t2_stall_done", 32'(stall), 32'd0);
    pop_rd("t2_rd");
    nc(); req_valid = 1'b0;

    // 3: store leaves rd alone even if the bus returns junk
    nc(); issue(1'b1, 32'h0000_0004, 3'd2, 4'b1100, 32'hABCD_0000);
    exp_rd.push_back(model_rd); #1;
    chk("t3_stall_idle", 32'(stall), 32'd1);
    nc(); dresp_addr_ok = 1'b1; #1;
    chk("t3_dvalid", 32'(dreq_valid), 32'd1);
    chk("t3_dwrite", 32'(dreq_write), 32'd1);
    chk("t3_daddr", dreq_addr, 32'h0000_0004);
    chk("t3_dstrobe", 32'(dreq_strobe), 32'hc);
    chk("t3_ddata", dreq_data, 32'hABCD_0000);
    nc(); dresp_data_ok = 1'b1; dresp_data = 32'hFFFF_FFFF; #1;
    chk("t3_stall_data", 32'(stall), 32'd1);
    nc(); m_advance = 1'b1; #1;
    chk("t3_stall_done", 32'(stall), 32'd0);
    pop_rd("t3_rd");
    nc(); req_valid = 1'b0;

    // 5: held result while the stage is frozen elsewhere
    nc(); issue(1'b0, 32'h0000_0020, 3'd2, 4'hf, 32'h0);
    model_rd = 32'h55AA_55AA; exp_rd.push_back(model_rd);
    nc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h55AA_55AA;
    nc(); #1;
    pop_rd("t5_rd");
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_hold", 32'(stall), 32'd0);
      chk("t5_rd_hold", rd, model_rd);
      chk("t5_dvalid_hold", 32'(dreq_valid), 32'd0);
      nc(); dresp_data_ok = 1'b1; dresp_data = 32'h0BAD_0BAD; #1;
    end
    m_advance = 1'b1;

    // 4: flush in DATA; next request waits for the drain
    nc(); issue(1'b0, 32'h0000_0040, 3'd2, 4'hf, 32'h0); #1;
    chk("t5_idle_after_adv", 32'(stall), 32'd1);
    nc(); dresp_addr_ok = 1'b1; #1;
    chk("t4_dvalid_old", 32'(dreq_valid), 32'd1);
    nc(); flush = 1'b1; #1;
    chk("t4_stall_flush", 32'(stall), 32'd1);
    nc(); issue(1'b0, 32'h0000_0080, 3'd2, 4'hf, 32'h0); #1;
    chk("t4_stall_disc", 32'(stall), 32'd1);
    chk("t4_dvalid_disc", 32'(dreq_valid), 32'd0);
    req_valid = 1'b0; #1;
    chk("t4_stall_novalid", 32'(stall), 32'd0);
    req_valid = 1'b1;
    nc(); dresp_data_ok = 1'b1; dresp_data = 32'hBAD0_BAD0; #1;
    chk("t4_stall_resp", 32'(stall), 32'd1);
    nc(); model_rd = 32'hC0FF_EE00; exp_rd.push_back(model_rd); #1;
    chk("t4_rd_kept", rd, 32'h55AA_55AA);
    chk("t4_stall_newidle", 32'(stall), 32'd1);
    chk("t4_dvalid_newidle", 32'(dreq_valid), 32'd0);
    nc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hC0FF_EE00; #1;
    chk("t4_dvalid_new", 32'(dreq_valid), 32'd1);
    chk("t4_daddr_new", dreq_addr, 32'h0000_0080);
    nc(); m_advance = 1'b1; #1;
    pop_rd("t4_rd");
    nc(); req_valid = 1'b0;

    // 6: async reset mid-ADDR
    nc(); issue(1'b0, 32'h0000_0200, 3'd2, 4'hf, 32'h0);
    nc(); #1;
    chk("t6_dvalid_pre", 32'(dreq_valid), 32'd1);
    #1 resetn = 1'b0; #1;
    chk("t6_dvalid_rst", 32'(dreq_valid), 32'd0);
    chk("t6_stall_rst", 32'(stall), 32'd0);
    chk("t6_rd_rst", rd, 32'd0);
    model_rd = '0; req_valid = 1'b0;
    nc(); nc(); resetn = 1'b1; #1;
    chk("t6_dvalid_post", 32'(dreq_valid), 32'd0);
    nc(); issue(1'b0, 32'h0000_0300, 3'd2, 4'hf, 32'h0);
    model_rd = 32'h7777_1111; exp_rd.push_back(model_rd); #1;
    chk("t6_stall_idle", 32'(stall), 32'd1);
    nc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h7777_1111; #1;
    chk("t6_dvalid_new", 32'(dreq_valid), 32'd1);
    chk("t6_daddr_new", dreq_addr, 32'h0000_0300);
    nc(); m_advance = 1'b1; #1;
    pop_rd("t6_rd");
    nc(); req_valid = 1'b0; #1;
    chk("sb_empty", 32'(exp_rd.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
